hilo_mac_unit: RTL and testbench



---
 rtl/mips_pkg.sv | 6 +
 rtl/hilo_shift_add_mul.sv | 41 ++++
 rtl/hilo_mac_unit.sv | 79 +++++++
 tb/tb_hilo_mac_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared HI/LO op codes, MAC FSM states and datapath width
package mips_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {OP_NONE, OP_MULT, OP_MADD, OP_MSUB} hilo_op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
endpackage

// File: rtl/hilo_shift_add_mul.sv
// hilo_shift_add_mul: iterative unsigned shift-add multiplier (start loads a/b and does the first step, busy while steps remain, product = a*b)
module hilo_shift_add_mul
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   product
);
  localparam int K = DATA_W / MUL_CYCLES;
  localparam int CW = $clog2(MUL_CYCLES) + 1;
  logic [2*DATA_W-1:0] mcand, src_mc, acc;
  logic [DATA_W-1:0] mplier, src_mp;
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb begin
    src_mc = start ? {{DATA_W{1'b0}}, a} : mcand;
    src_mp = start ? b : mplier;
    cnt_nxt = start ? CW'(MUL_CYCLES - 1) : cnt - 1'b1;
    acc = start ? '0 : product;
    for (int i = 0; i < K; i++) acc = acc + (src_mp[i] ? src_mc << i : '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand <= '0;
      mplier <= '0;
      product <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start || busy) begin
      product <= acc;
      mcand <= src_mc << K;
      mplier <= src_mp >> K;
      cnt <= cnt_nxt;
      busy <= cnt_nxt != '0;
    end
endmodule

// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit: multicycle mult/multu/madd/msub plus mthi/mtlo onto HI/LO (request in, Accept comb, Busy/Done registered, Hi/Lo out)
module hilo_mac_unit
  import mips_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  input  logic              HiLoWrite,
  input  logic              Madd,
  input  logic              Msub,
  input  logic              IsSigned,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              MtHi,
  input  logic              MtLo,
  input  logic [DATA_W-1:0] WrData,
  output logic              Accept,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);
  state_t state;
  hilo_op_t op, op_in;
  logic neg, mul_busy;
  logic [DATA_W-1:0] mag_a, mag_b;
  logic [2*DATA_W-1:0] product, prod_s, res;
  always_comb begin
    op_in = Madd ? OP_MADD : Msub ? OP_MSUB : HiLoWrite ? OP_MULT : OP_NONE;
    Accept = In_Valid && state == S_IDLE && op_in != OP_NONE;
    mag_a = IsSigned && A[DATA_W-1] ? -A : A;
    mag_b = IsSigned && B[DATA_W-1] ? -B : B;
    prod_s = neg ? -product : product;
    res = op == OP_MADD ? {Hi, Lo} + prod_s : op == OP_MSUB ? {Hi, Lo} - prod_s : prod_s;
  end
  hilo_shift_add_mul #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk(Clk),
    .rst_n(Rst_n),
    .start(Accept),
    .a(mag_a),
    .b(mag_b),
    .busy(mul_busy),
    .product(product)
  );
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= S_IDLE;
      op <= OP_NONE;
      neg <= 1'b0;
      Hi <= '0;
      Lo <= '0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE:
          if (Accept) begin
            op <= op_in;
            neg <= IsSigned && (A[DATA_W-1] ^ B[DATA_W-1]);
            Busy <= 1'b1;
            state <= S_MUL;
          end else begin
            if (MtHi) Hi <= WrData;
            if (MtLo) Lo <= WrData;
          end
        S_MUL: if (!mul_busy) state <= S_FIX;
        S_FIX: begin
          {Hi, Lo} <= res;
          Done <= 1'b1;
          Busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_hilo_mac_unit.sv
// tb_hilo_mac_unit: randomized self-checking bench for hilo_mac_unit against a 64-bit HI:LO arithmetic model
module tb_hilo_mac_unit;
  localparam int MC = 32;
  logic Clk = 0, Rst_n = 0, In_Valid = 0, HiLoWrite = 0, Madd = 0, Msub = 0, IsSigned = 0, MtHi = 0, MtLo = 0;
  logic [31:0] A = 0, B = 0, WrData = 0;
  logic Accept, Busy, Done;
  logic [31:0] Hi, Lo;
  int checks = 0, errors = 0;
  logic [63:0] m_hilo = 0;
  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
  always #5 Clk = ~Clk;
  hilo_mac_unit #(.MUL_CYCLES(MC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .HiLoWrite(HiLoWrite), .Madd(Madd), .Msub(Msub),
    .IsSigned(IsSigned), .A(A), .B(B), .MtHi(MtHi), .MtLo(MtLo), .WrData(WrData),
    .Accept(Accept), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );
  function automatic logic [63:0] prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!s) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction
  function automatic logic [31:0] pick();
    int idx;
    idx = int'($urandom_range(0, 4));
    return $urandom_range(0, 2) == 0 ? corners[idx] : $urandom;
  endfunction
  task automatic clear_in();
    In_Valid = 0; HiLoWrite = 0; Madd = 0; Msub = 0; IsSigned = 0; MtHi = 0; MtLo = 0;
  endtask
  task automatic drive_op(input int kind, input logic s, input logic [31:0] a, input logic [31:0] b);
    In_Valid = 1; HiLoWrite = kind == 0; Madd = kind == 1; Msub = kind == 2; IsSigned = s; A = a; B = b;
  endtask
  task automatic model_op(input int kind, input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = prod(s, a, b);
    m_hilo = kind == 0 ? p : kind == 1 ? m_hilo + p : m_hilo - p;
  endtask
  task automatic wait_done(output int cyc, output int bcyc);
    cyc = 0; bcyc = 0;
    while (!Done && cyc < 200) begin
      if (Busy) bcyc++;
      @(posedge Clk); #1;
      cyc++;
    end
  endtask
  task automatic run_op(input int kind, input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic acc, output int cyc, output int bcyc);
    @(negedge Clk);
    drive_op(kind, s, a, b);
    #1 acc = Accept;
    @(posedge Clk); #1;
    clear_in();
    model_op(kind, s, a, b);
    wait_done(cyc, bcyc);
  endtask
  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    @(negedge Clk);
    MtHi = h; MtLo = l; WrData = d;
    @(posedge Clk); #1;
    clear_in();
    if (h) m_hilo[63:32] = d;
    if (l) m_hilo[31:0] = d;
  endtask
  task automatic test_reset();
    #12;
    checks++; if (Hi !== 0 || Lo !== 0) begin errors++; $display("FAIL reset_hilo got %h_%h exp 0", Hi, Lo); end
    checks++; if (Busy !== 0 || Done !== 0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", Busy, Done); end
    checks++; if (Accept !== 0) begin errors++; $display("FAIL reset_accept got %b exp 0", Accept); end
    @(negedge Clk) Rst_n = 1;
  endtask
  task automatic test_mult();
    int kinds [3] = '{0, 0, 0};
    logic sg [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] va [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vb [3] = '{32'd5, 32'hFFFFFFFF, 32'h80000000};
    logic [63:0] ve [3] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'h40000000_00000000};
    logic acc;
    int cyc, bcyc;
    for (int i = 0; i < 3; i++) begin
      run_op(kinds[i], sg[i], va[i], vb[i], acc, cyc, bcyc);
      checks++; if (acc !== 1) begin errors++; $display("FAIL mult%0d_accept got %b exp 1", i, acc); end
      checks++; if (cyc !== MC + 1) begin errors++; $display("FAIL mult%0d_latency got %0d exp %0d", i, cyc, MC + 1); end
      checks++; if (bcyc !== MC + 1) begin errors++; $display("FAIL mult%0d_busy_cycles got %0d exp %0d", i, bcyc, MC + 1); end
      checks++; if ({Hi, Lo} !== ve[i] || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL mult%0d_result got %h_%h exp %h", i, Hi, Lo, ve[i]); end
      @(posedge Clk); #1;
      checks++; if (Done !== 0) begin errors++; $display("FAIL mult%0d_done_pulse got %b exp 0", i, Done); end
    end
  endtask
  task automatic test_mt_madd();
    logic acc;
    int cyc, bcyc;
    mt(0, 1, 32'd10);
    mt(1, 0, 32'd0);
    checks++; if ({Hi, Lo} !== 64'd10) begin errors++; $display("FAIL mt_write got %h_%h exp %h", Hi, Lo, 64'd10); end
    run_op(1, 1, 32'd2, 32'd3, acc, cyc, bcyc);
    checks++; if ({Hi, Lo} !== 64'd16 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL madd_result got %h_%h exp %h", Hi, Lo, 64'd16); end
    run_op(2, 1, 32'd1, 32'd17, acc, cyc, bcyc);
    checks++; if ({Hi, Lo} !== '1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL msub_result got %h_%h exp ffffffff_ffffffff", Hi, Lo); end
  endtask
  task automatic test_busy_ignore();
    logic [31:0] a, b;
    logic [63:0] prev;
    int cyc, bcyc;
    a = pick(); b = pick();
    prev = m_hilo;
    @(negedge Clk);
    drive_op(0, 1, a, b);
    @(posedge Clk); #1;
    clear_in();
    model_op(0, 1, a, b);
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    drive_op(0, 1, pick(), pick());
    MtHi = 1; WrData = 32'h1234;
    #1;
    checks++; if (Accept !== 0) begin errors++; $display("FAIL busy_accept got %b exp 0", Accept); end
    @(posedge Clk); #1;
    clear_in();
    checks++; if (Hi !== prev[63:32]) begin errors++; $display("FAIL busy_mthi got %h exp %h", Hi, prev[63:32]); end
    wait_done(cyc, bcyc);
    checks++; if ({Hi, Lo} !== m_hilo) begin errors++; $display("FAIL busy_result got %h_%h exp %h", Hi, Lo, m_hilo); end
  endtask
  task automatic test_back_to_back();
    logic acc;
    logic [31:0] a, b;
    int cyc, bcyc;
    run_op(1, 1, pick(), pick(), acc, cyc, bcyc);
    checks++; if (Done !== 1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL b2b_first got done=%b %h_%h exp done=1 %h", Done, Hi, Lo, m_hilo); end
    a = pick(); b = pick();
    drive_op(1, 1, a, b);
    #1;
    checks++; if (Accept !== 1) begin errors++; $display("FAIL b2b_accept got %b exp 1", Accept); end
    @(posedge Clk); #1;
    clear_in();
    model_op(1, 1, a, b);
    wait_done(cyc, bcyc);
    checks++; if (cyc !== MC + 1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL b2b_second got cyc=%0d %h_%h exp cyc=%0d %h", cyc, Hi, Lo, MC + 1, m_hilo); end
  endtask
  task automatic test_async_reset();
    logic acc;
    int cyc, bcyc, seen;
    mt(1, 1, 32'hA5A5A5A5);
    @(negedge Clk);
    drive_op(0, 1, pick(), pick());
    @(posedge Clk); #1;
    clear_in();
    repeat (10) @(posedge Clk);
    #2 Rst_n = 0;
    #1;
    m_hilo = 0;
    checks++; if ({Hi, Lo} !== 64'd0 || Busy !== 0) begin errors++; $display("FAIL areset_now got %h_%h busy=%b exp 0 0", Hi, Lo, Busy); end
    repeat (2) @(posedge Clk);
    @(negedge Clk) Rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done || Busy) seen++;
    end
    checks++; if (seen !== 0 || {Hi, Lo} !== 64'd0) begin errors++; $display("FAIL areset_discard got %0d activity cycles %h_%h exp 0", seen, Hi, Lo); end
    run_op(0, 0, pick(), pick(), acc, cyc, bcyc);
    checks++; if (acc !== 1 || cyc !== MC + 1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL areset_next got acc=%b cyc=%0d %h_%h exp %h", acc, cyc, Hi, Lo, m_hilo); end
  endtask
  task automatic test_random();
    logic acc;
    logic [31:0] a, b, d;
    logic s;
    int kind, cyc, bcyc;
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 5));
      a = pick(); b = pick(); d = $urandom; s = 1'($urandom);
      if (kind <= 2) begin
        run_op(kind, s, a, b, acc, cyc, bcyc);
        checks++; if (acc !== 1 || cyc !== MC + 1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL rand%0d_op%0d got acc=%b cyc=%0d %h_%h exp %h", n, kind, acc, cyc, Hi, Lo, m_hilo); end
      end else if (kind == 3) begin
        mt(1'($urandom), 1'($urandom), d);
        checks++; if ({Hi, Lo} !== m_hilo) begin errors++; $display("FAIL rand%0d_mt got %h_%h exp %h", n, Hi, Lo, m_hilo); end
      end else if (kind == 4) begin
        @(negedge Clk);
        In_Valid = 1; IsSigned = s; A = a; B = b;
        #1 acc = Accept;
        @(posedge Clk); #1;
        clear_in();
        checks++; if (acc !== 0 || Busy !== 0 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL rand%0d_noop got acc=%b busy=%b %h_%h exp 0 0 %h", n, acc, Busy, Hi, Lo, m_hilo); end
      end else begin
        @(negedge Clk);
        drive_op(0, s, a, b);
        MtHi = 1; MtLo = 1; WrData = d;
        #1 acc = Accept;
        @(posedge Clk); #1;
        clear_in();
        model_op(0, s, a, b);
        wait_done(cyc, bcyc);
        checks++; if (acc !== 1 || {Hi, Lo} !== m_hilo) begin errors++; $display("FAIL rand%0d_acc_vs_mt got acc=%b %h_%h exp %h", n, acc, Hi, Lo, m_hilo); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_mt_madd();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
